// File: rtl/ltc2324_pkg.sv
// ltc2324_pkg
// Shared types and constants for the LTC2324-16 device-side emulator.
//   DATA_W     sample word width
//   NUM_CH     number of serial data lanes (SDO1..SDO4)
//   BIT_CNT_W  width of the readout bit counter (counts 0..16)
//   state_e    emulator FSM states
//   RAMP_INIT  per-channel ramp seeds, channel n (1-based) starts at (n-1)*16'h4000

package ltc2324_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_CH    = 4;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_READ = 2'd2
    } state_e;

    // Index 0 is channel 1.
    localparam logic [NUM_CH-1:0][DATA_W-1:0] RAMP_INIT = {
        16'hC000, 16'h8000, 16'h4000, 16'h0000
    };

endpackage

// File: rtl/ltc2324_edge_sync.sv
// ltc2324_edge_sync
// Brings one asynchronous pin into the clk domain and reports its edges.
//   clk      emulator clock
//   rst_n    asynchronous active-low reset
//   pin_i    asynchronous input pin
//   level_o  synchronized, registered pin level (SYNC_STAGES+1 cycles behind the pin)
//   rise_o   1-cycle strobe, aligned with level_o going high
//   fall_o   1-cycle strobe, aligned with level_o going low

module ltc2324_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // The cast drops the oldest bit, which keeps this valid for SYNC_STAGES=1.
            sync_q  <= SYNC_STAGES'({sync_q, pin_i});
            level_q <= sync_out;
            rise_q  <= sync_out & ~level_q;
            fall_q  <= ~sync_out & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ltc2324_16_emulator.sv
// ltc2324_16_emulator
// Device-side model of the 4-channel, 16-bit LTC2324-16 serial ADC, for loopback
// bring-up of the ADC capture path. CNV/SCK are oversampled on clk (clk >= 4x SCK).
//   clk, rst_n         emulator clock, asynchronous active-low reset
//   CNV, SCK           conversion start and serial clock from the driver (async)
//   CLKOUT             synchronized SCK echoed back, registered
//   SDO1..SDO4         serial data lanes, MSB first, change only after SCK falls
//   pattern_sel        0: send ch*_in words, 1: send internal ramps
//   ch1_in..ch4_in     sample words, captured when a conversion starts
//   sample_take        1-cycle pulse when a sample set is captured
//   busy               high while converting or reading out
//   proto_err          sticky: CNV rise or SCK edge during conversion

module ltc2324_16_emulator
    import ltc2324_pkg::*;
#(
    parameter int                TCONV_CLKS  = 24,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RAMP_STEP   = 16'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CNV,
    input  logic              SCK,
    output logic              CLKOUT,
    output logic              SDO1,
    output logic              SDO2,
    output logic              SDO3,
    output logic              SDO4,
    input  logic              pattern_sel,
    input  logic [DATA_W-1:0] ch1_in,
    input  logic [DATA_W-1:0] ch2_in,
    input  logic [DATA_W-1:0] ch3_in,
    input  logic [DATA_W-1:0] ch4_in,
    output logic              sample_take,
    output logic              busy,
    output logic              proto_err
);

    localparam int CNT_W = $clog2(TCONV_CLKS + 1);

    logic cnv_level, cnv_rise, cnv_fall;
    logic sck_level, sck_rise, sck_fall;
    logic unused_cnv;

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                conv_cnt_q, conv_cnt_d;
    logic [BIT_CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   shift_q, shift_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   ramp_q, ramp_d;
    logic                            proto_err_q, proto_err_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   ch_in;
    logic                            capture;
    logic [NUM_CH-1:0]               sdo;

    ltc2324_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (CNV),
        .level_o (cnv_level),
        .rise_o  (cnv_rise),
        .fall_o  (cnv_fall)
    );

    ltc2324_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (SCK),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    // The CNV level and falling edge carry no meaning for the device.
    assign unused_cnv = cnv_level ^ cnv_fall;

    assign ch_in = {ch4_in, ch3_in, ch2_in, ch1_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            conv_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ramp_q      <= RAMP_INIT;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            conv_cnt_q  <= conv_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ramp_q      <= ramp_d;
            proto_err_q <= proto_err_d;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        conv_cnt_d  = conv_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ramp_d      = ramp_q;
        proto_err_d = proto_err_q;
        capture     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cnv_rise) capture = 1'b1;
            end
            S_CONV: begin
                // The driver must stay quiet while the device converts.
                if (cnv_rise || sck_rise || sck_fall) proto_err_d = 1'b1;
                if (conv_cnt_q == CNT_W'(TCONV_CLKS - 1)) begin
                    state_d = S_READ;
                end else begin
                    conv_cnt_d = conv_cnt_q + CNT_W'(1);
                end
            end
            S_READ: begin
                // A new CNV aborts the frame and takes priority over a coincident SCK fall.
                if (cnv_rise) begin
                    capture = 1'b1;
                end else if (sck_fall) begin
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        shift_d[ch] = {shift_q[ch][DATA_W-2:0], 1'b0};
                    end
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    // After the 16th fall the frame is complete: bit_cnt rests at 16
                    // and the device goes idle, so extra SCKs see SDO=0 and no error.
                    if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                shift_d[ch] = pattern_sel ? ramp_q[ch] : ch_in[ch];
                ramp_d[ch]  = ramp_q[ch] + RAMP_STEP;
            end
            conv_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_CONV;
        end
    end

    // The MSB of each shift register drives its lane only during readout.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sdo[ch] = (state_q == S_READ) & shift_q[ch][DATA_W-1];
        end
    end

    assign SDO1        = sdo[0];
    assign SDO2        = sdo[1];
    assign SDO3        = sdo[2];
    assign SDO4        = sdo[3];
    assign CLKOUT      = sck_level;
    assign sample_take = capture;
    assign busy        = (state_q != S_IDLE);
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ltc2324_16_emulator.sv
// tb_ltc2324_16_emulator
// Directed bench for ltc2324_16_emulator. Two instances share CNV/SCK: dut0 with a
// unit ramp step and selectable pattern, dutw with a 16'h4000 step fixed on the ramp
// so 16-bit wrap shows up within a couple of frames. A frame-level model tracks which
// words each conversion must return; a compare process checks every SDO lane at
// every CLKOUT rise and rebuilds the received words for literal checks.

module tb_ltc2324_16_emulator;

    localparam int TCONV = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              CNV = 1'b0;
    logic              SCK = 1'b0;
    logic              pattern_sel = 1'b0;
    logic [15:0]       stim [4];

    logic [1:0]        clkout_w;
    logic [1:0][3:0]   sdo_w;
    logic [1:0]        st_w;
    logic [1:0]        busy_w;
    logic [1:0]        perr_w;

    always #5 clk = ~clk;

    ltc2324_16_emulator #(.TCONV_CLKS(TCONV), .SYNC_STAGES(2), .RAMP_STEP(16'h0001)) dut0 (
        .clk(clk), .rst_n(rst_n), .CNV(CNV), .SCK(SCK), .CLKOUT(clkout_w[0]),
        .SDO1(sdo_w[0][0]), .SDO2(sdo_w[0][1]), .SDO3(sdo_w[0][2]), .SDO4(sdo_w[0][3]),
        .pattern_sel(pattern_sel),
        .ch1_in(stim[0]), .ch2_in(stim[1]), .ch3_in(stim[2]), .ch4_in(stim[3]),
        .sample_take(st_w[0]), .busy(busy_w[0]), .proto_err(perr_w[0])
    );

    ltc2324_16_emulator #(.TCONV_CLKS(TCONV), .SYNC_STAGES(2), .RAMP_STEP(16'h4000)) dutw (
        .clk(clk), .rst_n(rst_n), .CNV(CNV), .SCK(SCK), .CLKOUT(clkout_w[1]),
        .SDO1(sdo_w[1][0]), .SDO2(sdo_w[1][1]), .SDO3(sdo_w[1][2]), .SDO4(sdo_w[1][3]),
        .pattern_sel(1'b1),
        .ch1_in(stim[0]), .ch2_in(stim[1]), .ch3_in(stim[2]), .ch4_in(stim[3]),
        .sample_take(st_w[1]), .busy(busy_w[1]), .proto_err(perr_w[1])
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [15:0] model_ramp [2][4];
    logic [15:0] model_step [2];
    logic [15:0] exp_word   [2][4];
    bit          in_read = 1'b0;
    int          gen = 0;
    int          st_count = 0;

    task automatic model_reset();
        for (int ch = 0; ch < 4; ch++) begin
            model_ramp[0][ch] = 16'(ch * 16'h4000);
            model_ramp[1][ch] = 16'(ch * 16'h4000);
        end
        in_read = 1'b0;
        gen++;
    endtask

    // A conversion that the device accepts: freeze the words it must return.
    task automatic model_capture();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
                exp_word[d][ch]   = (d == 1 || pattern_sel) ? model_ramp[d][ch] : stim[ch];
                model_ramp[d][ch] = model_ramp[d][ch] + model_step[d];
            end
        end
        in_read = 1'b0;
        gen++;
    endtask

    // ---------------- compare process ----------------
    int          idx      [2];
    int          seen_gen [2];
    logic [15:0] rx       [2][4];
    logic [1:0]  clkout_prev = 2'b00;

    always @(negedge clk) begin
        logic expb;
        if (st_w[0]) st_count++;
        for (int d = 0; d < 2; d++) begin
            if (seen_gen[d] != gen) begin
                seen_gen[d] = gen;
                idx[d] = 0;
                for (int ch = 0; ch < 4; ch++) rx[d][ch] = '0;
            end
            if (clkout_w[d] && !clkout_prev[d]) begin
                for (int ch = 0; ch < 4; ch++) begin
                    expb = (in_read && idx[d] < 16) ? exp_word[d][ch][15 - idx[d]] : 1'b0;
                    check($sformatf("sdo dut%0d ch%0d bit%0d", d, ch + 1, idx[d]),
                          32'(sdo_w[d][ch]), 32'(expb));
                    if (in_read && idx[d] < 16) rx[d][ch] = {rx[d][ch][14:0], sdo_w[d][ch]};
                end
                if (in_read) idx[d]++;
            end
            clkout_prev[d] = clkout_w[d];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cnv_pulse(input bit expect_capture);
        int st0;
        st0 = st_count;
        CNV = 1'b1;
        if (expect_capture) model_capture();
        tick(4);
        CNV = 1'b0;
        tick(2);
        check("sample_take pulses", 32'(st_count - st0), expect_capture ? 32'd1 : 32'd0);
    endtask

    task automatic wait_conv();
        tick(TCONV + 10);
        in_read = 1'b1;
    endtask

    task automatic sck_cycles(input int n);
        repeat (n) begin
            SCK = 1'b1;
            tick(4);
            SCK = 1'b0;
            tick(4);
        end
    endtask

    task automatic frame(input int nsck);
        cnv_pulse(1'b1);
        check("busy in conversion", 32'(busy_w[0]), 32'd1);
        wait_conv();
        sck_cycles(nsck);
        tick(4);
        check("busy after frame", 32'(busy_w[0]), 32'd0);
    endtask

    task automatic check_rx(input string name, input int d,
                            input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] w4);
        check({name, " ch1"}, 32'(rx[d][0]), 32'(w1));
        check({name, " ch2"}, 32'(rx[d][1]), 32'(w2));
        check({name, " ch3"}, 32'(rx[d][2]), 32'(w3));
        check({name, " ch4"}, 32'(rx[d][3]), 32'(w4));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " SDO"},         32'(sdo_w[0]),  32'd0);
        check({name, " CLKOUT"},      32'(clkout_w[0]), 32'd0);
        check({name, " busy"},        32'(busy_w[0]), 32'd0);
        check({name, " sample_take"}, 32'(st_w[0]),   32'd0);
        check({name, " proto_err"},   32'(perr_w[0]), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    localparam logic [15:0] WRAP_CH4 [3] = '{16'hC000, 16'h0000, 16'h4000};

    initial begin
        model_step[0] = 16'h0001;
        model_step[1] = 16'h4000;
        for (int d = 0; d < 2; d++) seen_gen[d] = 0;
        stim = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        model_reset();
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(3);

        // Ramp pattern over three frames; dutw ch4 wraps C000 -> 0000.
        pattern_sel = 1'b1;
        for (int f = 0; f < 3; f++) begin
            frame(16);
            check($sformatf("ramp f%0d ch1", f), 32'(rx[0][0]), 32'(16'h0000 + f));
            check($sformatf("ramp f%0d ch2", f), 32'(rx[0][1]), 32'(16'h4000 + f));
            check($sformatf("ramp f%0d ch4", f), 32'(rx[0][3]), 32'(16'hC000 + f));
            check($sformatf("wrap f%0d ch4", f), 32'(rx[1][3]), 32'(WRAP_CH4[f]));
        end

        // External words.
        pattern_sel = 1'b0;
        stim = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF};
        frame(16);
        check_rx("ext words", 0, 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF);

        // Over-clocked frame: bits 17..20 read 0, no error.
        stim = '{16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00};
        frame(20);
        check_rx("20 sck", 0, 16'h8001, 16'h7FFE, 16'h00FF, 16'hFF00);
        check("proto_err after 20 sck", 32'(perr_w[0]), 32'd0);

        // Abort after 8 SCKs; the new capture is what comes out.
        stim = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        cnv_pulse(1'b1);
        wait_conv();
        sck_cycles(8);
        tick(2);
        check("busy mid-frame", 32'(busy_w[0]), 32'd1);
        stim = '{16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3};
        cnv_pulse(1'b1);
        wait_conv();
        sck_cycles(16);
        tick(4);
        check_rx("abort", 0, 16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3);
        check("proto_err after abort", 32'(perr_w[0]), 32'd0);

        // SCK and a second CNV inside the conversion window.
        stim = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        cnv_pulse(1'b1);
        tick(4);
        SCK = 1'b1;
        tick(4);
        SCK = 1'b0;
        tick(4);
        stim = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        cnv_pulse(1'b0);
        check("proto_err in conv", 32'(perr_w[0]), 32'd1);
        wait_conv();
        sck_cycles(16);
        tick(4);
        check_rx("conv violation", 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        check("proto_err sticky", 32'(perr_w[0]), 32'd1);

        // Reset at SCK #6 of a ramp frame.
        pattern_sel = 1'b1;
        cnv_pulse(1'b1);
        wait_conv();
        sck_cycles(5);
        SCK = 1'b1;
        tick(1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("mid-frame reset");
        tick(2);
        SCK = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        sck_cycles(4);
        tick(4);
        check("busy after reset release", 32'(busy_w[0]), 32'd0);
        check("sample_take none after reset", 32'(st_w[0]), 32'd0);

        // Ramps restart from their seeds.
        frame(16);
        check_rx("post-reset ramp", 0, 16'h0000, 16'h4000, 16'h8000, 16'hC000);
        check_rx("post-reset wrap", 1, 16'h0000, 16'h4000, 16'h8000, 16'hC000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
